mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Latches the execute-to-memory bus under a valid/allowin handshake and waits for the data SRAM response when the instruction is a load. Selects the final result (load data or ALU result) and forwards it to write-back. Also exports destination/result bypass signals and a load-pending flag to decode for forwarding and stall decisions.

## Interface
- No parameters. Bus widths come from shared defines: `ES_TO_MS_BUS_WD` = 72, `MS_TO_WS_BUS_WD` = 70.
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  write-back can accept this cycle
- ms_allowin  out  1  this stage can accept from execute
- es_to_ms_valid  in  1  execute presents a valid instruction
- es_to_ms_bus  in  72  {mem_we[71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- ms_to_ws_valid  out  1  valid instruction offered to write-back
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  load return data; qualified by data_ok
- data_sram_data_ok  in  1  one-cycle pulse per load response; stores never pulse this port
- ms_dest  out  5  destination register, forced to 0 when stage invalid or gr_we=0
- ms_to_ds_result  out  32  final_result, for decode bypass
- ms_load_wait  out  1  valid load still awaiting data_ok; decode must stall on dest match

## Operation
- State machine `ms_state`:
  - EMPTY: stage holds no instruction.
  - WAIT: holds a valid load, data not yet returned.
  - READY: result available, waiting to pass to write-back.
- Accept: when es_to_ms_valid && ms_allowin, latch the bus. Next state is WAIT if res_from_mem=1, otherwise READY.
- ms_allowin = EMPTY || (ms_ready_go && ws_allowin).
- ms_ready_go = READY || (WAIT && data_sram_data_ok).
- ms_to_ws_valid = (state != EMPTY) && ms_ready_go.
- WAIT transitions:
  - data_ok && ws_allowin: leave this cycle.
  - data_ok && !ws_allowin: capture rdata into `load_data_r`, go to READY.
- Leaving READY/WAIT with no new accept → EMPTY. Leaving with a simultaneous accept → the new instruction's WAIT/READY.
- final_result:
  - load && WAIT: data_sram_rdata, passed through combinationally.
  - load && READY: load_data_r.
  - otherwise: alu_result.
- Only full-word loads; no byte or half-word extraction in this block.
- data_ok in EMPTY or READY: ignored. An assertion flags it as a protocol error.
- mem_we is carried into the stage but not forwarded; stores complete in execute/store buffer.
- ms_load_wait = (state == WAIT) && !data_sram_data_ok.

## Timing
- Reset values: state EMPTY, bus register 0, load_data_r 0.
- Outputs under reset: ms_allowin=1, ms_to_ws_valid=0, ms_dest=0, ms_to_ds_result=0, ms_load_wait=0, ms_to_ws_bus=0.
- Reset mid-WAIT discards the instruction. A data_ok arriving in the reset cycle or after it is ignored.
- Non-load latency: 1 cycle. The result is on ms_to_ws_bus the cycle after accept.
- Load latency: 1 cycle + response delay.
  - data_ok in the first cycle after accept gives the same throughput as a non-load.
  - Each later cycle without data_ok adds one bubble.
- Back-to-back: full throughput, one instruction per cycle, with ws_allowin=1 and data_ok on time.
- ws_allowin low: ms_to_ws_bus and ms_to_ws_valid stay stable until consumed.
- All outputs except the ms_ready_go-dependent paths are registered-state decodes. data_ok→ms_to_ws_valid and rdata→final_result are combinational.

## Structure
- Shared package/header `mycpu.h` holds:
  - bus widths `ES_TO_MS_BUS_WD` and `MS_TO_WS_BUS_WD`;
  - new state constants `MS_EMPTY`, `MS_WAIT`, `MS_READY` (2-bit).
- No sub-module. The hold register and FSM are inline.

## Test plan
- ALU op, alu_result=0x1234_5678, dest=5, ws_allowin=1 → next cycle ms_to_ws_valid=1, final_result=0x1234_5678, ms_dest=5, ms_load_wait=0.
- Load, dest=8, data_ok 3 cycles after accept with rdata=0xDEAD_BEEF:
  - ms_load_wait=1 for 2 cycles, ms_allowin=0.
  - On data_ok: valid=1, final_result=0xDEAD_BEEF.
- Load, data_ok while ws_allowin=0, rdata=0xCAFE_0001, then rdata bus changes to 0xFFFF_FFFF:
  - stage holds READY;
  - when ws_allowin rises, final_result=0xCAFE_0001.
- Four back-to-back ALU ops with ws_allowin=1 → ms_allowin stays 1; results emerge on consecutive cycles in order.
- Reset asserted during WAIT, then a stray data_ok → state EMPTY, ms_to_ws_valid=0, no spurious result.
- Stage invalid with a stale bus holding dest=12 → ms_dest=0. Instruction with gr_we=0 → ms_dest=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stage states
// and the field layout of the execute-to-memory bus.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 72;
  localparam int MS_TO_WS_BUS_WD = 70;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_READY = 2'd2
  } ms_state_t;

  typedef struct packed {
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle around the memory stage: execute handshake, write-back
// handshake, data SRAM response and decode bypass.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [31:0]                data_sram_rdata;
  logic                       data_sram_data_ok;
  logic [4:0]                 ms_dest;
  logic [31:0]                ms_to_ds_result;
  logic                       ms_load_wait;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata, data_sram_data_ok,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_dest, ms_to_ds_result, ms_load_wait
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata, data_sram_data_ok,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_dest, ms_to_ds_result, ms_load_wait
  );

endinterface

// File: rtl/mem_stage_chk.sv
// Protocol checker for the memory stage: a load response may only arrive
// while a load is actually waiting for it.
module mem_stage_chk
  import mem_stage_pkg::*;
(
  input logic      clk,
  input logic      reset,
  input ms_state_t ms_state,
  input logic      data_ok
);

  a_data_ok_only_in_wait: assert property (
    @(posedge clk) disable iff (reset) data_ok |-> (ms_state == MS_WAIT)
  ) else $error("data_ok outside WAIT state");

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from execute, waits for the
// SRAM response on loads, and hands the final result on to write-back.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave ms
);

  ms_state_t   ms_state_r;
  ms_state_t   ms_state_nxt_s;
  es_to_ms_t   es_to_ms_bus_r;
  es_to_ms_t   es_in_s;
  logic [31:0] load_data_r;
  logic        ms_ready_go_s;
  logic        ms_allowin_s;
  logic        accept_s;
  logic        leave_s;
  logic        capture_s;
  ms_state_t   accept_state_s;
  logic [31:0] final_result_s;
  logic        unused_mem_we_s;

  assign es_in_s         = es_to_ms_t'(ms.es_to_ms_bus);
  assign ms_ready_go_s   = (ms_state_r == MS_READY) ||
                           ((ms_state_r == MS_WAIT) && ms.data_sram_data_ok);
  assign ms_allowin_s    = (ms_state_r == MS_EMPTY) || (ms_ready_go_s && ms.ws_allowin);
  assign accept_s        = ms.es_to_ms_valid && ms_allowin_s;
  assign leave_s         = (ms_state_r != MS_EMPTY) && ms_ready_go_s && ms.ws_allowin;
  assign capture_s       = (ms_state_r == MS_WAIT) && ms.data_sram_data_ok && !ms.ws_allowin;
  assign accept_state_s  = es_in_s.res_from_mem ? MS_WAIT : MS_READY;
  // Stores finish upstream; the flag rides along only so the bus layout matches.
  assign unused_mem_we_s = es_to_ms_bus_r.mem_we;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_state_r <= MS_EMPTY;
    end else begin
      ms_state_r <= ms_state_nxt_s;
    end
  end

  // Instruction hold register and captured load data
  always_ff @(posedge clk) begin
    if (reset) begin
      es_to_ms_bus_r <= '0;
      load_data_r    <= 32'd0;
    end else begin
      if (accept_s) begin
        es_to_ms_bus_r <= es_in_s;
      end
      if (capture_s) begin
        load_data_r <= ms.data_sram_rdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    ms_state_nxt_s = ms_state_r;
    case (ms_state_r)
      MS_EMPTY: begin
        if (accept_s) begin
          ms_state_nxt_s = accept_state_s;
        end else begin
          ms_state_nxt_s = MS_EMPTY;
        end
      end
      MS_WAIT: begin
        if (leave_s) begin
          ms_state_nxt_s = accept_s ? accept_state_s : MS_EMPTY;
        end else if (capture_s) begin
          ms_state_nxt_s = MS_READY;
        end else begin
          ms_state_nxt_s = MS_WAIT;
        end
      end
      MS_READY: begin
        if (leave_s) begin
          ms_state_nxt_s = accept_s ? accept_state_s : MS_EMPTY;
        end else begin
          ms_state_nxt_s = MS_READY;
        end
      end
      default: ms_state_nxt_s = MS_EMPTY;
    endcase
  end

  // Output decode; the WAIT path forwards SRAM data straight through
  always_comb begin
    final_result_s = es_to_ms_bus_r.alu_result;
    if (es_to_ms_bus_r.res_from_mem && (ms_state_r == MS_WAIT)) begin
      final_result_s = ms.data_sram_rdata;
    end else if (es_to_ms_bus_r.res_from_mem && (ms_state_r == MS_READY)) begin
      final_result_s = load_data_r;
    end else begin
      final_result_s = es_to_ms_bus_r.alu_result;
    end

    ms.ms_allowin      = ms_allowin_s;
    ms.ms_to_ws_valid  = (ms_state_r != MS_EMPTY) && ms_ready_go_s;
    ms.ms_to_ws_bus    = {es_to_ms_bus_r.gr_we, es_to_ms_bus_r.dest, final_result_s, es_to_ms_bus_r.pc};
    ms.ms_to_ds_result = final_result_s;
    ms.ms_load_wait    = (ms_state_r == MS_WAIT) && !ms.data_sram_data_ok;
    if ((ms_state_r != MS_EMPTY) && es_to_ms_bus_r.gr_we) begin
      ms.ms_dest = es_to_ms_bus_r.dest;
    end else begin
      ms.ms_dest = 5'd0;
    end
  end

endmodule
